// File: rtl/axi_cdc_chan_src.sv
// Source (write) side of one gray-pointer async FIFO channel.
// Ports: src_clk_i/src_rst_ni clock and async active-low reset;
//   src_data_i/src_valid_i/src_ready_o beat handshake in;
//   async_data_o storage array (entry i at [i*W +: W]);
//   async_wptr_o gray write pointer out; async_rptr_i gray read pointer in;
//   src_fill_o pessimistic occupancy 0..D.
module axi_cdc_chan_src #(
    parameter type         T          = logic,
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2,
    localparam int unsigned W         = $bits(T),
    localparam int unsigned D         = 2**LogDepth
) (
    input  logic                src_clk_i,
    input  logic                src_rst_ni,
    input  logic [W-1:0]        src_data_i,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    output logic [D*W-1:0]      async_data_o,
    output logic [LogDepth:0]   async_wptr_o,
    input  logic [LogDepth:0]   async_rptr_i,
    output logic [LogDepth:0]   src_fill_o
);

    typedef logic [LogDepth:0] ptr_t;

    localparam ptr_t DepthP = ptr_t'(D);

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        b[LogDepth] = g[LogDepth];
        for (int i = LogDepth - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    ptr_t                  wptr_bin_q, wptr_bin_d;
    ptr_t                  wptr_gray_q, wptr_gray_d;
    logic [D-1:0][W-1:0]   data_q;
    ptr_t                  rptr_sync_q [SyncStages];

    ptr_t                  rptr_bin;
    ptr_t                  fill;
    logic                  full;
    logic                  wr_en;

    assign rptr_bin = gray2bin(rptr_sync_q[SyncStages-1]);

    // Occupancy as seen from here; the MSB separates full from empty,
    // so fill == D is exactly the gray full condition.
    assign fill  = wptr_bin_q - rptr_bin;
    assign full  = (fill == DepthP);
    assign wr_en = src_valid_i & ~full;

    always_comb begin
        wptr_bin_d  = wptr_bin_q;
        wptr_gray_d = wptr_gray_q;
        if (wr_en) begin
            wptr_bin_d  = wptr_bin_q + 1'b1;
            wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);
        end
    end

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
            data_q      <= '0;
        end else begin
            wptr_bin_q  <= wptr_bin_d;
            wptr_gray_q <= wptr_gray_d;
            if (wr_en) begin
                data_q[wptr_bin_q[LogDepth-1:0]] <= src_data_i;
            end
        end
    end

    // Plain shift chain: no logic between stages.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            for (int i = 0; i < SyncStages; i++) begin
                rptr_sync_q[i] <= '0;
            end
        end else begin
            rptr_sync_q[0] <= async_rptr_i;
            for (int i = 1; i < SyncStages; i++) begin
                rptr_sync_q[i] <= rptr_sync_q[i-1];
            end
        end
    end

    assign src_ready_o  = ~full;
    assign src_fill_o   = fill;
    assign async_data_o = data_q;
    assign async_wptr_o = wptr_gray_q;

`ifndef SYNTHESIS
    ptr_t rptr_prev_q;

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            rptr_prev_q <= '0;
        end else begin
            rptr_prev_q <= async_rptr_i;
            assert (LogDepth >= 1 && SyncStages >= 2)
                else $error("bad LogDepth/SyncStages");
            assert (fill <= DepthP)
                else $error("fill exceeds depth");
            assert ($countones(async_rptr_i ^ rptr_prev_q) <= 1)
                else $error("async_rptr_i changed more than one bit");
        end
    end
`endif

endmodule

// File: tb/tb_axi_cdc_chan_src.sv
// Bench for axi_cdc_chan_src: vector table, corner sequences,
// and random traffic against a count-based FIFO model.
module tb_axi_cdc_chan_src;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        valid;
    logic        ready;
    logic [15:0] adata;
    logic [1:0]  wptr;
    logic [1:0]  rptr;
    logic [1:0]  fill;

    axi_cdc_chan_src #(
        .T          (logic [7:0]),
        .LogDepth   (1),
        .SyncStages (2)
    ) dut (
        .src_clk_i    (clk),
        .src_rst_ni   (rst_n),
        .src_data_i   (din),
        .src_valid_i  (valid),
        .src_ready_o  (ready),
        .async_data_o (adata),
        .async_wptr_o (wptr),
        .async_rptr_i (rptr),
        .src_fill_o   (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: total beats written, total beats read by the consumer,
    // the read count present at each past edge, and the slot contents.
    int         wcnt;
    int         rcnt;
    int         hist[$];
    logic [7:0] mem[2];
    logic [7:0] wlog[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        int         r;
        int         rep;
        logic       rdy;
        logic [1:0] wp;
        logic [1:0] fl;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] gray(input int n);
        logic [1:0] b;
        b = 2'(n % 4);
        return b ^ (b >> 1);
    endfunction

    // Read count known locally: the one present two edges ago.
    function automatic int seen();
        if (hist.size() >= 2) return hist[hist.size()-2];
        return 0;
    endfunction

    function automatic int m_fill();
        return wcnt - seen();
    endfunction

    function automatic logic m_ready();
        return m_fill() < 2;
    endfunction

    task automatic m_reset();
        wcnt = 0;
        rcnt = 0;
        hist.delete();
        wlog.delete();
        mem[0] = '0;
        mem[1] = '0;
    endtask

    task automatic cycle(input logic v, input logic [7:0] d);
        logic acc;
        valid = v;
        din   = d;
        rptr  = gray(rcnt);
        acc   = v && m_ready();
        @(posedge clk);
        if (acc) begin
            mem[wcnt % 2] = d;
            wlog.push_back(d);
            wcnt++;
        end
        hist.push_back(rcnt);
        if (hist.size() > 4) void'(hist.pop_front());
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"}, int'(ready), int'(m_ready()));
        chk({tag, ".wptr"},  int'(wptr),  int'(gray(wcnt)));
        chk({tag, ".fill"},  int'(fill),  m_fill());
        chk({tag, ".d0"},    int'(adata[7:0]),  int'(mem[0]));
        chk({tag, ".d1"},    int'(adata[15:8]), int'(mem[1]));
    endtask

    // Consumer reads the oldest unread slot, checking it was not overwritten.
    task automatic consume();
        chk("consume", int'(adata[(rcnt%2)*8 +: 8]), int'(wlog[rcnt]));
        rcnt++;
    endtask

    initial begin
        logic [1:0] prev;
        int         w0;
        int         tries;

        tbl[0] = '{1'b1, 8'hA1, 0, 1,  1'b1, 2'b01, 2'd1, 8'hA1, 8'h00};
        tbl[1] = '{1'b1, 8'hB2, 0, 1,  1'b0, 2'b11, 2'd2, 8'hA1, 8'hB2};
        tbl[2] = '{1'b1, 8'hC3, 0, 10, 1'b0, 2'b11, 2'd2, 8'hA1, 8'hB2};
        tbl[3] = '{1'b1, 8'hC3, 1, 1,  1'b0, 2'b11, 2'd2, 8'hA1, 8'hB2};
        tbl[4] = '{1'b1, 8'hC3, 1, 1,  1'b1, 2'b11, 2'd1, 8'hA1, 8'hB2};
        tbl[5] = '{1'b1, 8'hC3, 1, 1,  1'b0, 2'b10, 2'd2, 8'hC3, 8'hB2};
        tbl[6] = '{1'b0, 8'h00, 1, 1,  1'b0, 2'b10, 2'd2, 8'hC3, 8'hB2};

        rst_n = 1'b0;
        valid = 1'b0;
        din   = '0;
        rptr  = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst.ready", int'(ready), 1);
        chk("rst.wptr",  int'(wptr),  0);
        chk("rst.fill",  int'(fill),  0);
        chk("rst.data",  int'(adata), 0);

        // Fill, hold at full, then release via the read pointer.
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].rep; k++) begin
                rcnt = tbl[i].r;
                cycle(tbl[i].v, tbl[i].d);
                chk($sformatf("tbl%0d.ready", i), int'(ready), int'(tbl[i].rdy));
                chk($sformatf("tbl%0d.wptr", i),  int'(wptr),  int'(tbl[i].wp));
                chk($sformatf("tbl%0d.fill", i),  int'(fill),  int'(tbl[i].fl));
                chk($sformatf("tbl%0d.d0", i), int'(adata[7:0]),  int'(tbl[i].d0));
                chk($sformatf("tbl%0d.d1", i), int'(adata[15:8]), int'(tbl[i].d1));
            end
        end
        check_model("post_tbl");

        // Bring fill to 1, then write on the edge the synced rptr advances.
        rcnt = 2;
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        check_model("sim_pre");
        rcnt = 3;
        cycle(1'b0, 8'h00);
        chk("sim0.ready", int'(ready), 1);
        chk("sim0.fill",  int'(fill),  1);
        cycle(1'b1, 8'h5A);
        chk("sim1.ready", int'(ready), 1);
        chk("sim1.fill",  int'(fill),  1);
        cycle(1'b0, 8'h00);
        chk("sim2.ready", int'(ready), 1);
        chk("sim2.fill",  int'(fill),  1);
        check_model("sim");

        // Wrap: beats 0..7 with a consumer draining behind.
        for (int n = 0; n < 8; n++) begin
            tries = 0;
            while (tries < 20) begin
                if (rcnt < wcnt) consume();
                prev = wptr;
                w0   = wcnt;
                cycle(1'b1, 8'(n));
                check_model("wrap");
                if (wcnt != w0) break;
                tries++;
            end
            chk("wrap.accept", int'(tries < 20), 1);
            chk("wrap.1bit", $countones(prev ^ wptr), 1);
            chk("wrap.slot", int'(adata[((wcnt-1)%2)*8 +: 8]), n);
        end

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if (rcnt < wcnt && $urandom_range(0, 2) == 0) consume();
            cycle($urandom_range(0, 3) != 0, 8'($urandom));
            check_model("rnd");
        end

        // Reach fill=2, then reset between edges.
        for (int c = 0; c < 10 && m_fill() < 2; c++) begin
            cycle(1'b1, 8'($urandom));
        end
        chk("prerst.fill", int'(fill), 2);
        #3;
        rst_n = 1'b0;
        rptr  = '0;
        valid = 1'b0;
        #1;
        chk("arst.ready", int'(ready), 1);
        chk("arst.wptr",  int'(wptr),  0);
        chk("arst.fill",  int'(fill),  0);
        chk("arst.data",  int'(adata), 0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_model("post_rst");
        cycle(1'b1, 8'h77);
        check_model("post_rst_wr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
